if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline; the consumer of the decode controller's redirect outputs (PCSrc, IF_Flush, Jump, JumpR).
- Owns the PC and next-PC selection.
- Drives the instruction-cache request interface.
- Owns the IF/ID pipeline register, including bubble insertion and flush.
- Tracks a redirect that arrives while an instruction-cache miss is outstanding, so no wrong-path word ever enters ID.

---
 rtl/mips_pkg.sv | 30 +++
 rtl/if_fetch_stage_if_id_reg.sv | 48 ++++
 rtl/if_fetch_stage.sv | 142 ++++++++++++++
 tb/tb_if_fetch_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg
//   Definitions shared by the MIPS pipeline front end: the NOP encoding, the
//   default reset vector, the fetch-stage state encoding, the primary opcodes
//   the decode controller also uses, and a word-alignment helper.
package mips_pkg;

  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // out of reset, no request yet
    FETCH = 2'd1,  // normal fetching
    DRAIN = 2'd2   // waiting out a miss whose data is already known to be wrong-path
  } fetch_state_t;

  // Primary opcodes (instr[31:26]) shared with the decode controller.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Instruction addresses are word aligned; any target low bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// if_id_reg
//   IF/ID pipeline register. Control priority is hold > bubble > load; with
//   none asserted the register keeps its contents.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     hold            keep current contents (load-use stall)
//     bubble          replace the instruction with NOP_INST and clear valid
//     load            capture next_inst / next_pc4 as a valid instruction
//     next_inst/pc4   fetched word and its PC+4
//     inst/pc4/valid  register contents presented to ID
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        bubble,
  input  logic        load,
  input  logic [31:0] next_inst,
  input  logic [31:0] next_pc4,
  output logic [31:0] inst,
  output logic [31:0] pc4,
  output logic        valid
);

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst  <= NOP_INST;
      pc4   <= 32'h0;
      valid <= 1'b0;
    end else if (hold) begin
      // keep contents
    end else if (bubble) begin
      // pc4 is left as is; it is meaningless while valid is low
      inst  <= NOP_INST;
      valid <= 1'b0;
    end else if (load) begin
      inst  <= next_inst;
      pc4   <= next_pc4;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage
//   MIPS instruction-fetch stage: PC register, next-PC selection, I-cache
//   request interface and the IF/ID register. A redirect that lands while a
//   miss is outstanding is parked in pend_tgt and the FSM sits in DRAIN until
//   the old access completes, so the stale word never reaches ID.
//   Ports:
//     clk, rst                          clock, asynchronous active-high reset
//     stall                             load-use stall: freeze PC and IF/ID
//     PCSrc, IF_Flush, Jump, JumpR      redirect / squash requests from ID
//     branch_target, jump_index,
//     jr_target                         redirect target sources
//     ic_req, ic_addr                   cache request, word address pc[31:2]
//     ic_rdata, ic_stall                cache data and busy/miss indication
//     pc                                current fetch PC
//     if_id_inst, if_id_pc4,
//     if_id_valid                       IF/ID register outputs
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        PCSrc,
  input  logic        IF_Flush,
  input  logic        Jump,
  input  logic        JumpR,
  input  logic [31:0] branch_target,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  output logic        ic_req,
  output logic [29:0] ic_addr,
  input  logic [31:0] ic_rdata,
  input  logic        ic_stall,
  output logic [31:0] pc,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  fetch_state_t state;
  logic [31:0]  pend_tgt;
  logic [31:0]  pc_plus4;
  logic [31:0]  target;
  logic         redirect;
  logic         ifid_hold;
  logic         ifid_bubble;
  logic         ifid_load;

  assign ic_addr  = pc[31:2];
  assign pc_plus4 = pc + 32'd4;  // modulo 2^32
  assign redirect = PCSrc | Jump | JumpR;

  // Target priority JumpR > Jump > PCSrc; the j/jal region comes from the
  // PC+4 of the jump itself, which is the one sitting in IF/ID.
  always_comb begin
    target = branch_target;
    if (JumpR)     target = jr_target;
    else if (Jump) target = {if_id_pc4[31:28], jump_index, 2'b00};
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // one unassigned and infers a latch.
  always_comb begin
    ifid_hold   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_load   = 1'b0;
    case (state)
      FETCH: begin
        // stall outranks everything, so redirect/flush are ignored under it
        if (stall)                              ifid_hold   = 1'b1;
        else if (redirect || IF_Flush || ic_stall) ifid_bubble = 1'b1;
        else                                    ifid_load   = 1'b1;
      end
      DRAIN: begin
        if (stall) ifid_hold   = 1'b1;
        else       ifid_bubble = 1'b1;
      end
      default: ifid_bubble = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= word_align(RESET_PC);
      pend_tgt <= 32'h0;
      ic_req   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state  <= FETCH;
          ic_req <= 1'b1;
        end
        FETCH: begin
          if (!stall) begin
            if (redirect) begin
              if (!ic_stall) begin
                pc <= word_align(target);
              end else begin
                // the miss to the old pc must still complete; remember where to go
                pend_tgt <= word_align(target);
                state    <= DRAIN;
              end
            end else if (!ic_stall) begin
              pc <= pc_plus4;  // also covers the IF_Flush-only case
            end
          end
        end
        DRAIN: begin
          // redirect inputs are ignored here: ID holds a bubble
          if (!ic_stall) begin
            pc    <= pend_tgt;
            state <= FETCH;
          end
        end
        default: begin
          state  <= IDLE;
          ic_req <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg #(
    .NOP_INST(NOP_INST)
  ) u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .hold     (ifid_hold),
    .bubble   (ifid_bubble),
    .load     (ifid_load),
    .next_inst(ic_rdata),
    .next_pc4 (pc_plus4),
    .inst     (if_id_inst),
    .pc4      (if_id_pc4),
    .valid    (if_id_valid)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage
//   Directed bench for if_fetch_stage. The instruction cache is a
//   combinational memory image (word = 0x2400_0000 + byte address) whose
//   ic_stall is driven by the stimulus. Inputs change 1 ns after a rising
//   edge; outputs are checked at the same point.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, PCSrc, IF_Flush, Jump, JumpR;
  logic [31:0] branch_target, jr_target;
  logic [25:0] jump_index;
  logic        ic_req;
  logic [29:0] ic_addr;
  logic [31:0] ic_rdata;
  logic        ic_stall;
  logic [31:0] pc, if_id_inst, if_id_pc4;
  logic        if_id_valid;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] NOP = 32'h0000_0000;

  if_fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .PCSrc        (PCSrc),
    .IF_Flush     (IF_Flush),
    .Jump         (Jump),
    .JumpR        (JumpR),
    .branch_target(branch_target),
    .jump_index   (jump_index),
    .jr_target    (jr_target),
    .ic_req       (ic_req),
    .ic_addr      (ic_addr),
    .ic_rdata     (ic_rdata),
    .ic_stall     (ic_stall),
    .pc           (pc),
    .if_id_inst   (if_id_inst),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'h2400_0000 + addr;
  endfunction

  always_comb ic_rdata = mem_word({ic_addr, 2'b00});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // IF/ID holds a real instruction
  task automatic check_ifid(input string tag, input logic [31:0] inst, input logic [31:0] pc4);
    check({tag, " valid"}, {31'b0, if_id_valid}, 32'd1);
    check({tag, " inst"}, if_id_inst, inst);
    check({tag, " pc4"}, if_id_pc4, pc4);
  endtask

  task automatic check_bubble(input string tag);
    check({tag, " valid"}, {31'b0, if_id_valid}, 32'd0);
    check({tag, " inst"}, if_id_inst, NOP);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " pc"}, pc, 32'h0);
    check({tag, " ic_req"}, {31'b0, ic_req}, 32'd0);
    check({tag, " pc4"}, if_id_pc4, 32'h0);
    check_bubble(tag);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; PCSrc = 1'b0; IF_Flush = 1'b0; Jump = 1'b0; JumpR = 1'b0;
    branch_target = 32'h0; jr_target = 32'h0; jump_index = 26'h0; ic_stall = 1'b0;

    // ---- reset, then always-hit sequential fetch
    step(); step();
    check_reset("reset");
    rst = 1'b0;
    step();
    check("first req", {31'b0, ic_req}, 32'd1);
    check("first pc", pc, 32'h0);
    check_bubble("idle->fetch");
    step();
    check("seq pc1", pc, 32'h4);
    check_ifid("seq0", mem_word(32'h0), 32'h4);
    step();
    check("seq pc2", pc, 32'h8);
    check_ifid("seq1", mem_word(32'h4), 32'h8);
    step();
    check("seq pc3", pc, 32'hC);
    check_ifid("seq2", mem_word(32'h8), 32'hC);
    check("seq addr", {2'b0, ic_addr}, 32'h3);
    step();
    check("seq pc4", pc, 32'h10);

    // ---- taken branch while hitting: one bubble
    PCSrc = 1'b1; branch_target = 32'h40;
    step();
    PCSrc = 1'b0;
    check("br pc", pc, 32'h40);
    check_bubble("br bubble");
    step();
    check("br pc next", pc, 32'h44);
    check_ifid("br word", mem_word(32'h40), 32'h44);

    // ---- jump priority: JumpR beats Jump
    JumpR = 1'b1; jr_target = 32'h1000_000C;
    step();
    JumpR = 1'b0;
    check("jr setup pc", pc, 32'h1000_000C);
    step();
    check_ifid("jr setup", mem_word(32'h1000_000C), 32'h1000_0010);
    Jump = 1'b1; JumpR = 1'b1; jr_target = 32'h200; jump_index = 26'h100;
    step();
    Jump = 1'b0; JumpR = 1'b0;
    check("jr over j", pc, 32'h200);
    check_bubble("jr bubble");

    // ---- plain Jump uses IF/ID pc4 region
    JumpR = 1'b1; jr_target = 32'h1000_000C;
    step();
    JumpR = 1'b0;
    step();
    check("j setup pc4", if_id_pc4, 32'h1000_0010);
    Jump = 1'b1; jump_index = 26'h100;
    step();
    Jump = 1'b0;
    check("j target", pc, 32'h1000_0400);

    // ---- IF_Flush alone: bubble, pc still advances
    step();
    check("pre flush pc", pc, 32'h1000_0404);
    IF_Flush = 1'b1;
    step();
    IF_Flush = 1'b0;
    check("flush pc", pc, 32'h1000_0408);
    check_bubble("flush");

    // ---- misaligned jr target and 32-bit pc wrap
    JumpR = 1'b1; jr_target = 32'hFFFF_FFFF;
    step();
    JumpR = 1'b0;
    check("align pc", pc, 32'hFFFF_FFFC);
    step();
    check("wrap pc", pc, 32'h0);
    check_ifid("wrap", mem_word(32'hFFFF_FFFC), 32'h0);

    // ---- redirect during a miss at pc=0x8
    JumpR = 1'b1; jr_target = 32'h4;
    step();
    JumpR = 1'b0;
    step();
    check("miss setup pc", pc, 32'h8);
    ic_stall = 1'b1; PCSrc = 1'b1; branch_target = 32'h80;
    step();
    PCSrc = 1'b0;
    check("drain1 pc", pc, 32'h8);
    check("drain1 req", {31'b0, ic_req}, 32'd1);
    check_bubble("drain1");
    // a redirect in DRAIN must be ignored
    JumpR = 1'b1; jr_target = 32'h500;
    step();
    JumpR = 1'b0;
    check("drain2 pc", pc, 32'h8);
    check_bubble("drain2");
    step();
    check("drain3 pc", pc, 32'h8);
    check_bubble("drain3");
    ic_stall = 1'b0;
    step();
    check("drain exit pc", pc, 32'h80);
    check("drain exit addr", {2'b0, ic_addr}, 32'h20);
    check_bubble("drain exit");
    step();
    check_ifid("post drain", mem_word(32'h80), 32'h84);
    check("post drain pc", pc, 32'h84);

    // ---- load-use stall with a simultaneous branch
    stall = 1'b1; PCSrc = 1'b1; branch_target = 32'h300;
    step();
    check("stall pc", pc, 32'h84);
    check_ifid("stall1", mem_word(32'h80), 32'h84);
    step();
    check("stall pc2", pc, 32'h84);
    check_ifid("stall2", mem_word(32'h80), 32'h84);
    stall = 1'b0; PCSrc = 1'b0;
    step();
    check("unstall pc", pc, 32'h88);
    check_ifid("unstall", mem_word(32'h84), 32'h88);

    // ---- async reset in the middle of DRAIN
    ic_stall = 1'b1; PCSrc = 1'b1; branch_target = 32'hC0;
    step();
    PCSrc = 1'b0;
    check("pre rst pc", pc, 32'h88);
    #2 rst = 1'b1;
    #1;
    check_reset("async rst");
    ic_stall = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("restart req", {31'b0, ic_req}, 32'd1);
    check("restart pc", pc, 32'h0);
    step();
    check("restart pc1", pc, 32'h4);
    check_ifid("restart", mem_word(32'h0), 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
